width_converter_fifo: RTL and testbench

- Synchronous single-clock FIFO with integer-ratio width conversion, written natively in RTL with no vendor IP.
- Supports narrow-to-wide and wide-to-narrow data paths, for example ADC 16-bit samples to an 8-bit byte stream, or 8-bit bytes to 32-bit words.
- Sits between the sample capture logic and downstream serializer/packetizer logic.
- Adds occupancy counts, lane ordering control and sticky error flags.

---
 rtl/width_converter_fifo.sv | 142 ++++++++++++++
 tb/tb_width_converter_fifo.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/width_converter_fifo.sv
// Single-clock lane FIFO with integer-ratio width conversion between write and read ports.
// Define WIDTH_CONVERTER_FWFT_EN for first-word fall-through output; default is 1-cycle-latency read.
module width_converter_fifo #(
    parameter int IN_W        = 16,
    parameter int OUT_W       = 8,
    parameter int DEPTH_LANES = 64,
    parameter int MSB_FIRST   = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             wr_en,
    input  logic [IN_W-1:0]                  din,
    output logic                             full,
    input  logic                             rd_en,
    output logic [OUT_W-1:0]                 dout,
    output logic                             empty,
    output logic [$clog2(DEPTH_LANES):0]     wr_count,
    output logic [$clog2(DEPTH_LANES):0]     rd_count,
    output logic                             overflow,
    output logic                             underflow
);
    localparam int LANE_W = (IN_W < OUT_W) ? IN_W : OUT_W;
    localparam int MAX_W  = (IN_W < OUT_W) ? OUT_W : IN_W;
    localparam int WL     = IN_W / LANE_W;
    localparam int RL     = OUT_W / LANE_W;
    localparam int AW     = $clog2(DEPTH_LANES);
    localparam int PW     = AW + 1;

    generate
        if ((MAX_W % LANE_W) != 0 || (DEPTH_LANES & (DEPTH_LANES - 1)) != 0 ||
            DEPTH_LANES < 2 * (MAX_W / LANE_W)) begin : g_bad_params
            $error("width_converter_fifo: illegal width ratio or depth");
        end
    endgenerate

    logic [LANE_W-1:0] mem [DEPTH_LANES];

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    count_q, count_d, wr_count_q, wr_count_d;
    logic             full_q, full_d, empty_q, empty_d;
    logic             overflow_q, overflow_d, underflow_q, underflow_d;
    logic [OUT_W-1:0] dout_q, dout_d, rd_word;
    logic             wr_acc, rd_acc;

    logic [LANE_W-1:0] wr_lane [WL];
    logic [AW-1:0]     wr_addr [WL];
    logic [AW-1:0]     rd_addr [RL];

    // Lane 0 is always the one at the pointer; MSB_FIRST only decides where it sits in the word.
    generate
        for (genvar gi = 0; gi < WL; gi++) begin : g_wr_lane
            assign wr_addr[gi] = wr_ptr_q[AW-1:0] + AW'(gi);
            if (MSB_FIRST != 0) begin : g_msb
                assign wr_lane[gi] = din[IN_W-1-gi*LANE_W -: LANE_W];
            end else begin : g_lsb
                assign wr_lane[gi] = din[gi*LANE_W +: LANE_W];
            end
        end
        for (genvar gi = 0; gi < RL; gi++) begin : g_rd_lane
            assign rd_addr[gi] = rd_ptr_q[AW-1:0] + AW'(gi);
            if (MSB_FIRST != 0) begin : g_msb
                assign rd_word[OUT_W-1-gi*LANE_W -: LANE_W] = mem[rd_addr[gi]];
            end else begin : g_lsb
                assign rd_word[gi*LANE_W +: LANE_W] = mem[rd_addr[gi]];
            end
        end
    endgenerate

    assign wr_acc = wr_en & ~full_q;
    assign rd_acc = rd_en & ~empty_q;

`ifdef WIDTH_CONVERTER_FWFT_EN
    logic          out_valid_q, out_valid_d, load;
    logic [PW-1:0] ram_count;
    assign ram_count = wr_ptr_q - rd_ptr_q;
    assign load      = (ram_count >= PW'(RL)) && (!out_valid_q || rd_acc);
`endif

    always_comb begin
        wr_ptr_d    = wr_acc ? wr_ptr_q + PW'(WL) : wr_ptr_q;
        // count tracks every stored lane, including any held in the output register
        count_d     = count_q + (wr_acc ? PW'(WL) : '0) - (rd_acc ? PW'(RL) : '0);
        wr_count_d  = PW'(DEPTH_LANES) - count_d;
        full_d      = wr_count_d < PW'(WL);
        overflow_d  = overflow_q | (wr_en & full_q);
        underflow_d = underflow_q | (rd_en & empty_q);
`ifdef WIDTH_CONVERTER_FWFT_EN
        rd_ptr_d    = load ? rd_ptr_q + PW'(RL) : rd_ptr_q;
        dout_d      = load ? rd_word : dout_q;
        out_valid_d = load | (out_valid_q & ~rd_acc);
        empty_d     = ~out_valid_d;
`else
        rd_ptr_d    = rd_acc ? rd_ptr_q + PW'(RL) : rd_ptr_q;
        dout_d      = rd_acc ? rd_word : dout_q;
        empty_d     = count_d < PW'(RL);
`endif
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < WL; i++) begin
            if (wr_acc) mem[wr_addr[i]] <= wr_lane[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            wr_count_q  <= PW'(DEPTH_LANES);
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            dout_q      <= '0;
`ifdef WIDTH_CONVERTER_FWFT_EN
            out_valid_q <= 1'b0;
`endif
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            wr_count_q  <= wr_count_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            dout_q      <= dout_d;
`ifdef WIDTH_CONVERTER_FWFT_EN
            out_valid_q <= out_valid_d;
`endif
        end
    end

    assign full      = full_q;
    assign empty     = empty_q;
    assign dout      = dout_q;
    assign rd_count  = count_q;
    assign wr_count  = wr_count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
endmodule

// File: tb/tb_width_converter_fifo.sv
// Directed bench for width_converter_fifo: 16->8 (both lane orders) and 8->32 instances.
module tb_width_converter_fifo;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // A (MSB first) and B (LSB first) share stimulus
    logic        wr_en = 1'b0, rd_en = 1'b0;
    logic [15:0] din = '0;
    logic [7:0]  a_dout, b_dout;
    logic        a_full, a_empty, a_ovf, a_udf, b_full, b_empty, b_ovf, b_udf;
    logic [6:0]  a_wr_count, a_rd_count, b_wr_count, b_rd_count;

    logic        c_wr_en = 1'b0, c_rd_en = 1'b0;
    logic [7:0]  c_din = '0;
    logic [31:0] c_dout;
    logic        c_full, c_empty, c_ovf, c_udf;
    logic [6:0]  c_wr_count, c_rd_count;

    int n_checks = 0;
    int n_fail = 0;

    width_converter_fifo #(.IN_W(16), .OUT_W(8), .DEPTH_LANES(64), .MSB_FIRST(1)) u_a (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .din(din), .full(a_full), .rd_en(rd_en),
        .dout(a_dout), .empty(a_empty), .wr_count(a_wr_count), .rd_count(a_rd_count),
        .overflow(a_ovf), .underflow(a_udf));

    width_converter_fifo #(.IN_W(16), .OUT_W(8), .DEPTH_LANES(64), .MSB_FIRST(0)) u_b (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .din(din), .full(b_full), .rd_en(rd_en),
        .dout(b_dout), .empty(b_empty), .wr_count(b_wr_count), .rd_count(b_rd_count),
        .overflow(b_ovf), .underflow(b_udf));

    width_converter_fifo #(.IN_W(8), .OUT_W(32), .DEPTH_LANES(64), .MSB_FIRST(1)) u_c (
        .clk(clk), .rst_n(rst_n), .wr_en(c_wr_en), .din(c_din), .full(c_full), .rd_en(c_rd_en),
        .dout(c_dout), .empty(c_empty), .wr_count(c_wr_count), .rd_count(c_rd_count),
        .overflow(c_ovf), .underflow(c_udf));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr16(input logic [15:0] d);
        wr_en = 1'b1;
        din   = d;
        step();
        wr_en = 1'b0;
        $display("wr din=%04h rd_count=%0d full=%0b", d, a_rd_count, a_full);
    endtask

    task automatic rd8(input string tag, input logic [7:0] exp);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        $display("rd dout=%02h exp=%02h", a_dout, exp);
        check(tag, a_dout, exp);
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, "_empty"}, a_empty, 1'b1);
        check({tag, "_full"}, a_full, 1'b0);
        check({tag, "_wr_count"}, a_wr_count, 7'd64);
        check({tag, "_rd_count"}, a_rd_count, 7'd0);
        check({tag, "_dout"}, a_dout, 8'h00);
        check({tag, "_ovf"}, a_ovf, 1'b0);
        check({tag, "_udf"}, a_udf, 1'b0);
    endtask

    logic [7:0]  ea [4];
    logic [7:0]  eb [4];
    logic [7:0]  exp_b;
    logic [15:0] w;
    logic        w_ok, r_ok;
    logic [7:0]  mq [$];

    initial begin
        #12;
        check_reset_a("rst_in");
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        check_reset_a("rst_idle");

`ifdef WIDTH_CONVERTER_FWFT_EN
        wr16(16'h1234);
        step();
        check("fwft_empty", a_empty, 1'b0);
        check("fwft_dout0", a_dout, 8'h12);
        check("fwft_rd_count0", a_rd_count, 7'd2);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        check("fwft_dout1", a_dout, 8'h34);
        check("fwft_rd_count1", a_rd_count, 7'd1);
`else
        // two words, four back-to-back byte reads, both lane orders
        ea = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        eb = '{8'hB2, 8'hA1, 8'hD4, 8'hC3};
        wr16(16'hA1B2);
        wr16(16'hC3D4);
        check("t2_rd_count", a_rd_count, 7'd4);
        check("t2_empty_pre", a_empty, 1'b0);
        for (int i = 0; i < 4; i++) begin
            rd_en = 1'b1;
            step();
            $display("rd a=%02h b=%02h", a_dout, b_dout);
            check("t2_a_dout", a_dout, ea[i]);
            check("t2_b_dout", b_dout, eb[i]);
        end
        rd_en = 1'b0;
        check("t2_empty", a_empty, 1'b1);
        check("t2_udf", a_udf, 1'b0);
        check("t2_b_empty", b_empty, 1'b1);

        // narrow-to-wide: three bytes leave a partial word
        for (int i = 1; i <= 4; i++) begin
            c_wr_en = 1'b1;
            c_din   = 8'(i * 8'h11);
            step();
            c_wr_en = 1'b0;
            $display("wr c din=%02h empty=%0b", c_din, c_empty);
            if (i == 3) check("n2w_partial_empty", c_empty, 1'b1);
        end
        check("n2w_empty", c_empty, 1'b0);
        c_rd_en = 1'b1;
        step();
        c_rd_en = 1'b0;
        $display("rd c dout=%08h", c_dout);
        check("n2w_dout", c_dout, 32'h11223344);
        check("n2w_empty_after", c_empty, 1'b1);

        // fill to full, overflow, drain in order
        for (int i = 0; i < 32; i++) begin
            w = {8'(i), 8'hF0 ^ 8'(i)};
            wr16(w);
            if (i == 30) check("fill_not_full", a_full, 1'b0);
        end
        check("fill_full", a_full, 1'b1);
        check("fill_wr_count", a_wr_count, 7'd0);
        wr16(16'hFFFF);
        check("ovf_flag", a_ovf, 1'b1);
        check("ovf_rd_count", a_rd_count, 7'd64);
        for (int k = 0; k < 64; k++) begin
            w = {8'(k / 2), 8'hF0 ^ 8'(k / 2)};
            rd8("drain_dout", (k % 2 == 0) ? w[15:8] : w[7:0]);
        end
        check("drain_empty", a_empty, 1'b1);
        check("drain_udf", a_udf, 1'b0);
        rd8("udf_dout_hold", 8'hEF);
        check("udf_flag", a_udf, 1'b1);
        check("udf_ovf_sticky", a_ovf, 1'b1);

        // concurrent read/write against a lane queue model, crossing the pointer wrap
        for (int i = 0; i < 5; i++) begin
            w = {8'h40 + 8'(i), 8'h80 + 8'(i)};
            wr16(w);
            mq.push_back(w[15:8]);
            mq.push_back(w[7:0]);
        end
        check("rw_start_count", a_rd_count, 7'd10);
        for (int c = 0; c < 100; c++) begin
            w     = {8'(c), ~8'(c)};
            din   = w;
            wr_en = 1'b1;
            rd_en = 1'b1;
            w_ok  = (64 - mq.size()) >= 2;
            r_ok  = mq.size() >= 1;
            exp_b = 8'h00;
            if (r_ok) exp_b = mq.pop_front();
            if (w_ok) begin
                mq.push_back(w[15:8]);
                mq.push_back(w[7:0]);
            end
            step();
            $display("rw c=%0d din=%04h dout=%02h rd_count=%0d", c, w, a_dout, a_rd_count);
            if (r_ok) check("rw_dout", a_dout, exp_b);
            check("rw_rd_count", a_rd_count, 7'(mq.size()));
        end

        // asynchronous reset mid-burst
        #3 rst_n = 1'b0;
        #1;
        check_reset_a("rst_mid");
        check("rst_mid_c_empty", c_empty, 1'b1);
        wr_en = 1'b0;
        rd_en = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        wr16(16'h5A6B);
        rd8("post_rst_rd0", 8'h5A);
        rd8("post_rst_rd1", 8'h6B);
        check("post_rst_empty", a_empty, 1'b1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
